// File: rtl/vga_sprite_engine_pkg.sv
`default_nettype none
// ============================================================================
// Package : vga_pkg
// Brief   : Default 640x480@60 timing, colour struct and counter-width helper.
// Rev     : 1.0
// ============================================================================
package vga_pkg;

    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;

    localparam int unsigned BTN_UP    = 0;
    localparam int unsigned BTN_DOWN  = 1;
    localparam int unsigned BTN_LEFT  = 2;
    localparam int unsigned BTN_RIGHT = 3;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_sprite_engine_if.sv
`default_nettype none
// ============================================================================
// Interface : vga_sprite_engine_if
// Brief     : Button inputs and VGA DAC outputs of the sprite engine.
// Rev       : 1.0
// ============================================================================
interface vga_sprite_engine_if;

    logic       move_up;
    logic       move_down;
    logic       move_left;
    logic       move_right;
    logic       oHS;
    logic       oVS;
    logic       oBLANK_n;
    logic [7:0] r_data;
    logic [7:0] g_data;
    logic [7:0] b_data;
    logic       frame_tick;

    modport master (
        input  move_up, move_down, move_left, move_right,
        output oHS, oVS, oBLANK_n, r_data, g_data, b_data, frame_tick
    );

    modport slave (
        output move_up, move_down, move_left, move_right,
        input  oHS, oVS, oBLANK_n, r_data, g_data, b_data, frame_tick
    );

endinterface
`default_nettype wire

// File: rtl/vga_sprite_engine_timing.sv
`default_nettype none
// ============================================================================
// Module : vga_timing_gen
// Brief  : Raster counters with registered sync, blank and end-of-frame pulse.
// Rev    : 1.0
// ============================================================================
module vga_timing_gen import vga_pkg::*; #(
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BP     = VGA_V_BP,
    parameter int unsigned HW       = cnt_width(H_ACTIVE + H_FP + H_SYNC + H_BP),
    parameter int unsigned VW       = cnt_width(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic          clock,
    input  logic          resetn,
    output logic [HW-1:0] h_cnt_o,
    output logic [VW-1:0] v_cnt_o,
    output logic          hs_o,
    output logic          vs_o,
    output logic          blank_n_o,
    output logic          frame_tick_o
);

    localparam logic [HW-1:0] c_h_last   = HW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [VW-1:0] c_v_last   = VW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [HW-1:0] c_h_act    = HW'(H_ACTIVE);
    localparam logic [VW-1:0] c_v_act    = VW'(V_ACTIVE);
    localparam logic [HW-1:0] c_hs_begin = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] c_hs_end   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] c_vs_begin = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] c_vs_end   = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic          hs_q, vs_q, blank_n_q, tick_q;

    always_comb begin
        h_cnt_d = h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == c_h_last) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == c_v_last) ? '0 : v_cnt_q + 1'b1;
        end
    end

    // Outputs are registered from the current count, so they lag it by one cycle.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            hs_q      <= !((h_cnt_q >= c_hs_begin) && (h_cnt_q < c_hs_end));
            vs_q      <= !((v_cnt_q >= c_vs_begin) && (v_cnt_q < c_vs_end));
            blank_n_q <= (h_cnt_q < c_h_act) && (v_cnt_q < c_v_act);
            tick_q    <= (h_cnt_q == c_h_last) && (v_cnt_q == c_v_last);
        end
    end

    assign h_cnt_o      = h_cnt_q;
    assign v_cnt_o      = v_cnt_q;
    assign hs_o         = hs_q;
    assign vs_o         = vs_q;
    assign blank_n_o    = blank_n_q;
    assign frame_tick_o = tick_q;

endmodule
`default_nettype wire

// File: rtl/vga_sprite_engine.sv
`default_nettype none
// ============================================================================
// Module : vga_sprite_engine
// Brief  : VGA raster generator with one button-steered rectangular sprite.
//          Define VGA_SPRITE_WRAP_EN to wrap at the screen edges instead of clamping.
// Rev    : 1.0
// ============================================================================
module vga_sprite_engine import vga_pkg::*; #(
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BP     = VGA_V_BP,
    parameter int unsigned SPR_W    = 32,
    parameter int unsigned SPR_H    = 32,
    parameter int unsigned STEP     = 4,
    parameter logic [23:0] SPR_RGB  = 24'hFF0000,
    parameter logic [23:0] BG_RGB   = 24'h000040
) (
    input  logic                  clock,
    input  logic                  resetn,
    vga_sprite_engine_if.master   vga_if
);

    localparam int unsigned c_h_tot = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned c_v_tot = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned c_hw    = cnt_width(c_h_tot);
    localparam int unsigned c_vw    = cnt_width(c_v_tot);

    localparam logic [c_hw-1:0] c_h_last  = c_hw'(c_h_tot - 1);
    localparam logic [c_vw-1:0] c_v_last  = c_vw'(c_v_tot - 1);
    localparam logic [c_hw-1:0] c_h_act   = c_hw'(H_ACTIVE);
    localparam logic [c_vw-1:0] c_v_act   = c_vw'(V_ACTIVE);
    localparam logic [c_hw-1:0] c_x_lim   = c_hw'(H_ACTIVE - SPR_W);
    localparam logic [c_vw-1:0] c_y_lim   = c_vw'(V_ACTIVE - SPR_H);
    localparam logic [c_hw:0]   c_x_max   = (c_hw+1)'(H_ACTIVE - SPR_W);
    localparam logic [c_vw:0]   c_y_max   = (c_vw+1)'(V_ACTIVE - SPR_H);
    localparam logic [c_hw:0]   c_x_step  = (c_hw+1)'(STEP);
    localparam logic [c_vw:0]   c_y_step  = (c_vw+1)'(STEP);
    localparam logic [c_hw:0]   c_spr_w   = (c_hw+1)'(SPR_W);
    localparam logic [c_vw:0]   c_spr_h   = (c_vw+1)'(SPR_H);
    localparam logic [c_hw-1:0] c_x_ctr   = c_hw'((H_ACTIVE - SPR_W) / 2);
    localparam logic [c_vw-1:0] c_y_ctr   = c_vw'((V_ACTIVE - SPR_H) / 2);

`ifdef VGA_SPRITE_WRAP_EN
    localparam bit c_wrap_en = 1'b1;
`else
    localparam bit c_wrap_en = 1'b0;
`endif

    logic [c_hw-1:0] w_h_cnt;
    logic [c_vw-1:0] w_v_cnt;
    logic            w_hs, w_vs, w_blank_n, w_tick;
    logic [3:0]      w_btn_raw;
    logic [3:0]      btn_meta_q, btn_sync_q, btn_q;
    logic [c_hw-1:0] spr_x_q, spr_x_d;
    logic [c_vw-1:0] spr_y_q, spr_y_d;
    logic [c_hw:0]   w_x_inc, w_x_dec, w_x_end;
    logic [c_vw:0]   w_y_inc, w_y_dec, w_y_end;
    logic            w_vis, w_in_spr;
    rgb_t            w_pix, pix_q;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
        .HW       (c_hw),     .VW   (c_vw)
    ) u_timing (
        .clock        (clock),
        .resetn       (resetn),
        .h_cnt_o      (w_h_cnt),
        .v_cnt_o      (w_v_cnt),
        .hs_o         (w_hs),
        .vs_o         (w_vs),
        .blank_n_o    (w_blank_n),
        .frame_tick_o (w_tick)
    );

    always_comb begin
        w_btn_raw            = '0;
        w_btn_raw[BTN_UP]    = vga_if.move_up;
        w_btn_raw[BTN_DOWN]  = vga_if.move_down;
        w_btn_raw[BTN_LEFT]  = vga_if.move_left;
        w_btn_raw[BTN_RIGHT] = vga_if.move_right;
    end

    // btn_q is sampled on the same edge that raises frame_tick, so it is fresh while the tick is high.
    always_comb begin
        w_x_inc = {1'b0, spr_x_q} + c_x_step;
        w_x_dec = {1'b0, spr_x_q} - c_x_step;
        w_y_inc = {1'b0, spr_y_q} + c_y_step;
        w_y_dec = {1'b0, spr_y_q} - c_y_step;
        spr_x_d = spr_x_q;
        spr_y_d = spr_y_q;
        if (w_tick && (btn_q[BTN_RIGHT] != btn_q[BTN_LEFT])) begin
            if (btn_q[BTN_RIGHT])
                spr_x_d = (w_x_inc > c_x_max) ? (c_wrap_en ? '0 : c_x_lim) : w_x_inc[c_hw-1:0];
            else
                spr_x_d = w_x_dec[c_hw] ? (c_wrap_en ? c_x_lim : '0) : w_x_dec[c_hw-1:0];
        end
        if (w_tick && (btn_q[BTN_DOWN] != btn_q[BTN_UP])) begin
            if (btn_q[BTN_DOWN])
                spr_y_d = (w_y_inc > c_y_max) ? (c_wrap_en ? '0 : c_y_lim) : w_y_inc[c_vw-1:0];
            else
                spr_y_d = w_y_dec[c_vw] ? (c_wrap_en ? c_y_lim : '0) : w_y_dec[c_vw-1:0];
        end
    end

    // Compare against the next position so pixel (0,0) already sees the new frame's sprite.
    always_comb begin
        w_x_end  = {1'b0, spr_x_d} + c_spr_w;
        w_y_end  = {1'b0, spr_y_d} + c_spr_h;
        w_vis    = (w_h_cnt < c_h_act) && (w_v_cnt < c_v_act);
        w_in_spr = (w_h_cnt >= spr_x_d) && ({1'b0, w_h_cnt} < w_x_end) &&
                   (w_v_cnt >= spr_y_d) && ({1'b0, w_v_cnt} < w_y_end);
        w_pix    = '0;
        if (w_vis)
            w_pix = w_in_spr ? rgb_t'(SPR_RGB) : rgb_t'(BG_RGB);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            btn_meta_q <= '0;
            btn_sync_q <= '0;
            btn_q      <= '0;
            spr_x_q    <= c_x_ctr;
            spr_y_q    <= c_y_ctr;
            pix_q      <= '0;
        end else begin
            btn_meta_q <= w_btn_raw;
            btn_sync_q <= btn_meta_q;
            if ((w_h_cnt == c_h_last) && (w_v_cnt == c_v_last))
                btn_q <= btn_sync_q;
            spr_x_q    <= spr_x_d;
            spr_y_q    <= spr_y_d;
            pix_q      <= w_pix;
        end
    end

    assign vga_if.oHS        = w_hs;
    assign vga_if.oVS        = w_vs;
    assign vga_if.oBLANK_n   = w_blank_n;
    assign vga_if.frame_tick = w_tick;
    assign vga_if.r_data     = pix_q.r;
    assign vga_if.g_data     = pix_q.g;
    assign vga_if.b_data     = pix_q.b;

endmodule
`default_nettype wire
